// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences single operations through a combinational ALU
// Registers operands, waits a fixed settle latency, captures and holds the result.
module alu_op_sequencer #(
  parameter int WIDTH   = 6,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [1:0]         req_func,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_func,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_ovf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_err,
  output logic [1:0]         rsp_func,
  output logic               busy,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   op_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam int WCW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic             rsp_hs;

  assign rsp_hs = (state == RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      req_ready  <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      rsp_func   <= '0;
      busy       <= 1'b0;
      op_count   <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_func  <= req_func;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            // Divide-by-zero never reaches the ALU result path
            if (req_func == 2'b11 && req_b == '0) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_func   <= req_func;
            end else begin
              state    <= EXEC;
              wait_cnt <= WCW'(LATENCY - 1);
            end
          end
        end
        EXEC: begin
          if (wait_cnt == '0) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_result <= alu_out;
            rsp_err    <= alu_ovf;
            rsp_func   <= alu_func;
          end else begin
            wait_cnt <= wait_cnt - WCW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase

      // Clear wins over a coincident handshake increment
      if (cnt_clr) begin
        op_count  <= '0;
        err_count <= '0;
      end else if (rsp_hs) begin
        if (op_count != '1) op_count <= op_count + CNT_W'(1);
        if (rsp_err && err_count != '1) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
// Two instances: default parameters, and LATENCY=1 / CNT_W=2 for saturation.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // add, sub, mul, divide {quotient,remainder}; bit 12 is overflow
  function automatic logic [12:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                            input logic [1:0] f);
    logic [12:0] r;
    case (f)
      2'b00: r = {1'b0, 12'(a) + 12'(b)};
      2'b01: r = {(b > a), 12'(a) - 12'(b)};
      2'b10: r = {1'b0, 12'(a) * 12'(b)};
      default: r = (b == 6'd0) ? 13'h1000 : {1'b0, a / b, a % b};
    endcase
    return r;
  endfunction

  // instance 0: WIDTH=6, LATENCY=2, CNT_W=8
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy, cnt_clr;
  logic [5:0]  req_a, req_b, alu_a, alu_b;
  logic [1:0]  req_func, alu_func, rsp_func;
  logic [11:0] alu_out, rsp_result;
  logic        alu_ovf, force_ovf;
  logic [7:0]  op_count, err_count;

  always_comb {alu_ovf, alu_out} = alu_model(alu_a, alu_b, alu_func) | {force_ovf, 12'h0};

  alu_op_sequencer #(.WIDTH(6), .LATENCY(2), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_func(req_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_func(rsp_func), .busy(busy), .cnt_clr(cnt_clr),
    .op_count(op_count), .err_count(err_count)
  );

  // instance 1: WIDTH=6, LATENCY=1, CNT_W=2
  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready, s_rsp_err, s_busy, s_cnt_clr;
  logic [5:0]  s_req_a, s_req_b, s_alu_a, s_alu_b;
  logic [1:0]  s_req_func, s_alu_func, s_rsp_func;
  logic [11:0] s_alu_out, s_rsp_result;
  logic        s_alu_ovf;
  logic [1:0]  s_op_count, s_err_count;

  always_comb {s_alu_ovf, s_alu_out} = alu_model(s_alu_a, s_alu_b, s_alu_func);

  alu_op_sequencer #(.WIDTH(6), .LATENCY(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_req_a), .req_b(s_req_b), .req_func(s_req_func),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_func(s_alu_func),
    .alu_out(s_alu_out), .alu_ovf(s_alu_ovf),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_result(s_rsp_result),
    .rsp_err(s_rsp_err), .rsp_func(s_rsp_func), .busy(s_busy), .cnt_clr(s_cnt_clr),
    .op_count(s_op_count), .err_count(s_err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [5:0] a, input logic [5:0] b, input logic [1:0] f);
    req_valid = 1'b1; req_a = a; req_b = b; req_func = f;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b0; force_ovf = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_func = '0; rsp_ready = 1'b0;
    s_req_valid = 1'b0; s_req_a = '0; s_req_b = '0; s_req_func = '0;
    s_rsp_ready = 1'b0; s_cnt_clr = 1'b0;
    step(); step();
    rst = 1'b0;

    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_rsp_result", rsp_result, 0);

    // add 5+3, latency 2
    rsp_ready = 1'b1;
    req(6'd5, 6'd3, 2'b00);
    chk("add_busy", busy, 1);
    chk("add_req_ready", req_ready, 0);
    chk("add_alu_a", alu_a, 5);
    chk("add_valid_c1", rsp_valid, 0);
    step();
    chk("add_valid_c2_low", rsp_valid, 0);
    step();
    chk("add_valid_c2", rsp_valid, 1);
    chk("add_result", rsp_result, 8);
    chk("add_err", rsp_err, 0);
    chk("add_func", rsp_func, 0);
    step();
    chk("add_done_valid", rsp_valid, 0);
    chk("add_done_ready", req_ready, 1);
    chk("add_op_count", op_count, 1);

    // divide 13/4 with back-pressure; foreign requests must be ignored
    rsp_ready = 1'b0;
    req(6'd13, 6'd4, 2'b11);
    step(); step();
    chk("div_valid", rsp_valid, 1);
    chk("div_result", rsp_result, 12'd193);
    req_valid = 1'b1; req_a = 6'd60; req_b = 6'd1; req_func = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div_hold_valid", rsp_valid, 1);
      chk("div_hold_result", rsp_result, 12'd193);
      chk("div_hold_ready", req_ready, 0);
    end
    chk("div_alu_a_held", alu_a, 13);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("div_after_ready", req_ready, 1);
    chk("div_after_valid", rsp_valid, 0);
    chk("div_op_count", op_count, 2);

    // divide by zero: one-cycle response
    rsp_ready = 1'b0;
    req(6'd9, 6'd0, 2'b11);
    chk("dz_valid", rsp_valid, 1);
    chk("dz_err", rsp_err, 1);
    chk("dz_result", rsp_result, 0);
    chk("dz_func", rsp_func, 3);
    rsp_ready = 1'b1;
    step();
    chk("dz_err_count", err_count, 1);
    chk("dz_op_count", op_count, 3);

    // forced ALU overflow, then a clean op
    force_ovf = 1'b1;
    req(6'd1, 6'd1, 2'b00);
    step();
    chk("ovf_valid_low", rsp_valid, 0);
    step();
    force_ovf = 1'b0;
    chk("ovf_valid", rsp_valid, 1);
    chk("ovf_err", rsp_err, 1);
    step();
    chk("ovf_err_count", err_count, 2);
    req(6'd7, 6'd2, 2'b01);
    step(); step();
    chk("sub_result", rsp_result, 5);
    chk("sub_err", rsp_err, 0);
    step();
    chk("sub_err_count", err_count, 2);
    chk("sub_op_count", op_count, 5);

    // reset during EXEC
    req(6'd3, 6'd4, 2'b10);
    chk("rstx_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstx_busy", busy, 0);
    chk("rstx_ready", req_ready, 1);
    chk("rstx_alu_a", alu_a, 0);
    chk("rstx_op_count", op_count, 0);
    step(); step();
    chk("rstx_no_rsp", rsp_valid, 0);

    // reset during RESP
    rsp_ready = 1'b0;
    req(6'd3, 6'd4, 2'b10);
    step(); step();
    chk("rstr_valid_pre", rsp_valid, 1);
    chk("rstr_result_pre", rsp_result, 12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstr_valid", rsp_valid, 0);
    chk("rstr_result", rsp_result, 0);
    chk("rstr_ready", req_ready, 1);

    // normal request after reset
    rsp_ready = 1'b1;
    req(6'd2, 6'd2, 2'b00);
    step(); step();
    chk("post_result", rsp_result, 4);
    step();
    chk("post_op_count", op_count, 1);

    // LATENCY=1, CNT_W=2: saturation and clear-wins
    s_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_req_valid = 1'b1; s_req_a = 6'(i); s_req_b = 6'd1; s_req_func = 2'b00;
      step();
      s_req_valid = 1'b0;
      step();
      chk("sat_valid_lat1", s_rsp_valid, 1);
      chk("sat_result", s_rsp_result, 12'(i + 1));
      step();
      chk("sat_op_count", s_op_count, (i < 3) ? (i + 1) : 3);
    end
    s_req_valid = 1'b1; s_req_a = 6'd1; s_req_b = 6'd1; s_req_func = 2'b00;
    step();
    s_req_valid = 1'b0;
    step();
    s_cnt_clr = 1'b1;
    step();
    s_cnt_clr = 1'b0;
    chk("clr_op_count", s_op_count, 0);
    chk("clr_valid", s_rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
